// File: rtl/array_result_serializer_pkg.sv
// Shared constants and helpers for the array result serializer.
// Holds the byte-count calculations, the FSM state encoding and the
// cell-index flattening convention used by the array processor.
package array_result_serializer_pkg;

   // FSM state encoding
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   // Bytes per cell after zero-extension to a whole number of bytes
   function automatic int unsigned cell_bytes(input int unsigned cell_width);
      return (cell_width + 7) / 8;
   endfunction

   // Bytes per frame
   function automatic int unsigned total_bytes(input int unsigned height,
                                               input int unsigned width,
                                               input int unsigned cell_width);
      return height * width * cell_bytes(cell_width);
   endfunction

   // Flattened cell index: cell k = row*width + col
   function automatic int unsigned cell_index(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned width);
      return row * width + col;
   endfunction

   // Counter width with a floor of one bit
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/array_result_serializer.sv
// Captures one flattened result array and emits it as a byte stream.
// Cells go out in increasing flattened index, most-significant byte first.
// Ports:
//   clock, reset        - clock, asynchronous active-high reset
//   enable              - global stall; low freezes all state
//   in_data/in_valid/in_ready/in_last - frame capture handshake
//   out_data/out_valid/out_ready/out_last - byte stream handshake
module array_result_serializer
   import array_result_serializer_pkg::*;
#(
   parameter int unsigned ARRAY_HEIGHT = 4,
   parameter int unsigned ARRAY_WIDTH  = 8,
   parameter int unsigned CELL_WIDTH   = 16
) (
   input  logic                                        clock,
   input  logic                                        reset,
   input  logic                                        enable,
   input  logic [ARRAY_WIDTH*ARRAY_HEIGHT*CELL_WIDTH-1:0] in_data,
   input  logic                                        in_valid,
   output logic                                        in_ready,
   input  logic                                        in_last,
   output logic [7:0]                                  out_data,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic                                        out_last
);

   localparam int unsigned CELL_BYTES  = cell_bytes(CELL_WIDTH);
   localparam int unsigned TOTAL_BYTES = total_bytes(ARRAY_HEIGHT, ARRAY_WIDTH, CELL_WIDTH);
   localparam int unsigned IDX_W       = clog2_min1(TOTAL_BYTES);
   localparam int unsigned EXT_W       = CELL_BYTES * 8;

   logic [0:0]       state_q;
   logic [0:0]       state_d;
   logic [IDX_W-1:0] index_q;
   logic [IDX_W-1:0] index_d;
   logic             last_flag_q;
   logic             capture;
   logic             at_end;
   logic [7:0]       frame_q       [TOTAL_BYTES];
   logic [7:0]       capture_bytes [TOTAL_BYTES];

   // Reorder the input array into transmit order: byte i of the frame is
   // stored at slot i, so the output side is a plain indexed read.
   for (genvar r = 0; r < ARRAY_HEIGHT; r++) begin : g_row
      for (genvar c = 0; c < ARRAY_WIDTH; c++) begin : g_col
         localparam int unsigned K = cell_index(r, c, ARRAY_WIDTH);
         logic [EXT_W-1:0] cell_ext;
         assign cell_ext = EXT_W'(in_data[K*CELL_WIDTH +: CELL_WIDTH]);
         for (genvar b = 0; b < CELL_BYTES; b++) begin : g_byte
            assign capture_bytes[K*CELL_BYTES + b] = cell_ext[(CELL_BYTES-1-b)*8 +: 8];
         end
      end
   end

   assign at_end = (index_q == IDX_W'(TOTAL_BYTES - 1));

   // Next-state and control
   always_comb begin
      state_d = state_q;
      index_d = index_q;
      capture = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable && in_valid) begin
               capture = 1'b1;
               index_d = '0;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (enable && out_ready) begin
               if (at_end) begin
                  index_d = '0;
                  state_d = ST_IDLE;
               end else begin
                  index_d = index_q + IDX_W'(1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and index registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         index_q <= '0;
      end else if (enable) begin
         state_q <= state_d;
         index_q <= index_d;
      end
   end

   // Frame buffer and last flag, loaded only on the capture handshake
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         frame_q     <= '{default: 8'h00};
         last_flag_q <= 1'b0;
      end else if (capture) begin
         frame_q     <= capture_bytes;
         last_flag_q <= in_last;
      end
   end

   // Handshake outputs decode directly from state so reset clears them at once
   assign in_ready  = (state_q == ST_IDLE) && enable && !reset;
   assign out_valid = (state_q == ST_SEND) && enable;
   assign out_data  = (state_q == ST_SEND) ? frame_q[index_q] : 8'h00;
   assign out_last  = (state_q == ST_SEND) && last_flag_q && at_end;

endmodule

// File: tb/tb_array_result_serializer.sv
// Self-checking bench for array_result_serializer (2x2 array, 12-bit cells).
// A queue-based reference model predicts the handshake and byte stream each cycle.
module tb_array_result_serializer;

   localparam int unsigned H   = 2;
   localparam int unsigned W   = 2;
   localparam int unsigned CW  = 12;
   localparam int unsigned CB  = 2;
   localparam int unsigned TOT = 8;
   localparam int unsigned DW  = H * W * CW;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic          clk       = 1'b0;
   logic          rst       = 1'b1;
   logic          en        = 1'b1;
   logic [DW-1:0] in_data   = '0;
   logic          in_valid  = 1'b0;
   logic          in_last   = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic [7:0]    out_data;
   logic          out_valid;
   logic          out_last;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   beat_t exp_q[$];
   beat_t rx_q[$];
   int    rx_cyc[$];

   logic [7:0] s1_gold [8];

   always #5 clk = ~clk;

   array_result_serializer #(
      .ARRAY_HEIGHT(H),
      .ARRAY_WIDTH (W),
      .CELL_WIDTH  (CW)
   ) dut (
      .clock    (clk),
      .reset    (rst),
      .enable   (en),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_last  (in_last),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last (out_last)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Byte i of a frame: cell i/CB, MSB-first within the zero-extended cell
   function automatic beat_t frame_beat(input logic [DW-1:0] d, input logic lst, input int i);
      beat_t        bt;
      int           k;
      int           b;
      logic [CW-1:0] v;
      k = i / CB;
      b = CB - 1 - (i % CB);
      v = d[k*CW +: CW];
      bt.data = 8'(64'(v) >> (8 * b));
      bt.last = lst && (i == TOT - 1);
      return bt;
   endfunction

   function automatic logic [DW-1:0] pack4(input logic [11:0] c0, input logic [11:0] c1,
                                           input logic [11:0] c2, input logic [11:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   // Reference model: a frame is a queue of pending bytes; empty means idle
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
      end else if (en) begin
         if (exp_q.size() == 0) begin
            if (in_valid) begin
               for (int i = 0; i < TOT; i++) exp_q.push_back(frame_beat(in_data, in_last, i));
            end
         end else if (out_ready) begin
            exp_q.delete(0);
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Per-cycle comparison against the model, plus collection of accepted bytes
   always @(negedge clk) begin
      check("in_ready", 64'(in_ready), 64'(!rst && en && exp_q.size() == 0));
      check("out_valid", 64'(out_valid), 64'(!rst && en && exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check("out_data", 64'(out_data), 64'(exp_q[0].data));
         check("out_last", 64'(out_last), 64'(exp_q[0].last));
      end else if (rst) begin
         check("rst_out_data", 64'(out_data), 64'h0);
         check("rst_out_last", 64'(out_last), 64'h0);
      end
      if (!rst && out_valid && out_ready) begin
         rx_q.push_back('{data: out_data, last: out_last});
         rx_cyc.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rx(input int n, input string tag);
      int guard = 0;
      while (rx_q.size() < n && guard < 200) begin
         step();
         guard++;
      end
      check(tag, 64'(rx_q.size()), 64'(n));
   endtask

   task automatic check_frame(input string tag, input int base, input logic [DW-1:0] d,
                              input logic lst);
      beat_t bt;
      if (rx_q.size() >= base + TOT) begin
         for (int i = 0; i < TOT; i++) begin
            bt = frame_beat(d, lst, i);
            check($sformatf("%s_byte%0d", tag, i), 64'(rx_q[base+i].data), 64'(bt.data));
            check($sformatf("%s_last%0d", tag, i), 64'(rx_q[base+i].last), 64'(bt.last));
         end
      end
   endtask

   initial begin
      logic [DW-1:0] fa;
      logic [DW-1:0] fb;
      logic          lb;
      int            lasts;

      s1_gold = '{8'h01, 8'h23, 8'h04, 8'h56, 8'h07, 8'h89, 8'h0A, 8'hBC};

      // Reset state
      repeat (3) step();
      #1;
      check("reset_in_ready", 64'(in_ready), 64'h0);
      check("reset_out_valid", 64'(out_valid), 64'h0);
      check("reset_out_data", 64'(out_data), 64'h0);
      step();
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", 64'(in_ready), 64'h1);

      // Scenario 1: single frame, full-rate sink
      rx_q.delete(); rx_cyc.delete();
      in_data  = pack4(12'h123, 12'h456, 12'h789, 12'hABC);
      in_last  = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("s1_first_valid", 64'(out_valid), 64'h1);
      check("s1_first_byte", 64'(out_data), 64'h01);
      check("s1_in_ready_busy", 64'(in_ready), 64'h0);
      wait_rx(8, "s1_count");
      check("s1_in_ready_after", 64'(in_ready), 64'h1);
      if (rx_q.size() >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check($sformatf("s1_byte%0d", i), 64'(rx_q[i].data), 64'(s1_gold[i]));
            check($sformatf("s1_last%0d", i), 64'(rx_q[i].last), 64'(i == 7));
         end
         check("s1_consecutive", 64'(rx_cyc[7] - rx_cyc[0]), 64'd7);
      end

      // Scenario 2: backpressure pattern 1,0,0,1
      rx_q.delete(); rx_cyc.delete();
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int c = 0; c < 100 && rx_q.size() < 8; c++) begin
         out_ready = ((c % 4) == 0) || ((c % 4) == 3);
         step();
      end
      out_ready = 1'b1;
      check("s2_count", 64'(rx_q.size()), 64'd8);
      check_frame("s2", 0, in_data, 1'b1);

      // Scenario 3: second frame held valid during SEND
      step();
      rx_q.delete(); rx_cyc.delete();
      fa = DW'({$urandom(), $urandom()});
      fb = DW'({$urandom(), $urandom()});
      lb = 1'($urandom_range(0, 1));
      in_data  = fa;
      in_last  = 1'b1;
      in_valid = 1'b1;
      step();
      in_data = fb;
      in_last = lb;
      wait_rx(9, "s3_second_start");
      in_valid = 1'b0;
      wait_rx(16, "s3_count");
      check_frame("s3a", 0, fa, 1'b1);
      check_frame("s3b", 8, fb, lb);
      if (rx_cyc.size() >= 9) check("s3_gap", 64'(rx_cyc[8] - rx_cyc[7]), 64'd2);

      // Scenario 4: enable low for 5 cycles after byte 3
      step();
      rx_q.delete(); rx_cyc.delete();
      in_data  = pack4(12'h123, 12'h456, 12'h789, 12'hABC);
      in_last  = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_rx(3, "s4_pre");
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("s4_stall_valid", 64'(out_valid), 64'h0);
         check("s4_stall_ready", 64'(in_ready), 64'h0);
         step();
      end
      en = 1'b1;
      #1;
      check("s4_resume_valid", 64'(out_valid), 64'h1);
      check("s4_resume_byte", 64'(out_data), 64'h56);
      wait_rx(8, "s4_count");
      check_frame("s4", 0, in_data, 1'b1);

      // Scenario 5: reset after 4 bytes
      step();
      rx_q.delete(); rx_cyc.delete();
      in_data  = DW'({$urandom(), $urandom()});
      in_last  = 1'b1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_rx(4, "s5_pre");
      #2;
      rst = 1'b1;
      #1;
      check("s5_rst_valid", 64'(out_valid), 64'h0);
      check("s5_rst_data", 64'(out_data), 64'h0);
      check("s5_rst_last", 64'(out_last), 64'h0);
      check("s5_rst_ready", 64'(in_ready), 64'h0);
      step();
      step();
      rst = 1'b0;
      #1;
      check("s5_release_ready", 64'(in_ready), 64'h1);
      repeat (10) step();
      check("s5_no_residual", 64'(rx_q.size()), 64'd4);

      // Scenario 6: frame without last
      rx_q.delete(); rx_cyc.delete();
      in_data  = DW'({$urandom(), $urandom()});
      in_last  = 1'b0;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_rx(8, "s6_count");
      check("s6_idle", 64'(in_ready), 64'h1);
      lasts = 0;
      foreach (rx_q[i]) if (rx_q[i].last) lasts++;
      check("s6_no_last", 64'(lasts), 64'd0);
      check_frame("s6", 0, in_data, 1'b0);

      // Randomised traffic, checked cycle by cycle against the model
      for (int c = 0; c < 400; c++) begin
         in_data   = DW'({$urandom(), $urandom()});
         in_last   = 1'($urandom_range(0, 1));
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         en        = ($urandom_range(0, 9) != 0);
         step();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      en        = 1'b1;
      repeat (20) step();
      check("rand_drained", 64'(in_ready), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
      $fatal(1);
   end

endmodule
